// File: rtl/serial_mod_pkg.sv
// Shared types and configuration check for the serial modulo-N detector.
package serial_mod_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } order_t;

    // A frame can only open with a non-zero divisor and a length of 1..max_len bits.
    function automatic logic cfg_legal(input int unsigned divisor,
                                       input int unsigned frame_len,
                                       input int unsigned max_len);
        return (divisor != 0) && (frame_len >= 1) && (frame_len <= max_len);
    endfunction

endpackage

// File: rtl/mod_n_step.sv
// Combinational (a + b + cin) mod n for a, b < n. The total stays below 2n,
// so one conditional subtract of n replaces a divider.
module mod_n_step #(
    parameter int DIV_W = 4
) (
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    input  logic             cin,
    input  logic [DIV_W-1:0] n,
    output logic [DIV_W-1:0] sum
);

    logic [DIV_W:0] raw;
    logic [DIV_W:0] diff;

    // Widen by one bit to hold the sum, then fold back into 0..n-1.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{DIV_W{1'b0}}, cin};
        diff = raw - {1'b0, n};
        if (raw >= {1'b0, n}) begin
            sum = diff[DIV_W-1:0];
        end else begin
            sum = raw[DIV_W-1:0];
        end
    end

endmodule

// File: rtl/serial_mod_n_detector.sv
// Serial divisibility detector: tracks the received bit stream modulo a
// run-time divisor, in MSB-first or LSB-first order, with bounded frames.
module serial_mod_n_detector
    import serial_mod_pkg::*;
#(
    parameter  int DIV_W   = 4,
    parameter  int MAX_LEN = 32,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] divisor,
    input  logic             lsb_first,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [DIV_W-1:0] rem_out,
    output logic             div_ok,
    output logic [LEN_W-1:0] bit_cnt,
    output logic             active,
    output logic             frame_done,
    output logic             cfg_err
);

    state_t           state_q, state_n;
    order_t           order_q, order_n;
    logic [DIV_W-1:0] n_q, n_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [DIV_W-1:0] rem_q, rem_n;
    logic [DIV_W-1:0] w_q, w_n;
    logic [LEN_W-1:0] cnt_q, cnt_n;
    logic             div_ok_q, div_ok_n;
    logic             done_q, done_n;
    logic             err_q, err_n;

    logic [DIV_W-1:0] rem_a, rem_b, rem_step, w_step;
    logic             rem_cin;
    logic             legal, accept;
    logic [LEN_W-1:0] cnt_inc;

    // MSB-first doubles the remainder and adds the bit; LSB-first adds the
    // current power-of-two weight when the bit is set.
    always_comb begin
        rem_a = rem_q;
        if (order_q == MSB_FIRST) begin
            rem_b   = rem_q;
            rem_cin = bit_in;
        end else begin
            rem_b   = bit_in ? w_q : '0;
            rem_cin = 1'b0;
        end
    end

    mod_n_step #(.DIV_W(DIV_W)) u_rem_step (
        .a   (rem_a),
        .b   (rem_b),
        .cin (rem_cin),
        .n   (n_q),
        .sum (rem_step)
    );

    mod_n_step #(.DIV_W(DIV_W)) u_weight_step (
        .a   (w_q),
        .b   (w_q),
        .cin (1'b0),
        .n   (n_q),
        .sum (w_step)
    );

    assign legal   = cfg_legal(32'(divisor), 32'(frame_len), MAX_LEN);
    assign accept  = (state_q == ACTIVE) && bit_valid && !start;
    assign cnt_inc = cnt_q + LEN_W'(1);

    // Next-state and next-output logic; start always wins over a bit.
    always_comb begin
        state_n  = state_q;
        order_n  = order_q;
        n_n      = n_q;
        len_n    = len_q;
        rem_n    = rem_q;
        w_n      = w_q;
        cnt_n    = cnt_q;
        div_ok_n = div_ok_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        if (start) begin
            rem_n    = '0;
            cnt_n    = '0;
            div_ok_n = 1'b0;
            if (legal) begin
                state_n = ACTIVE;
                order_n = order_t'(lsb_first);
                n_n     = divisor;
                len_n   = frame_len;
                w_n     = (divisor == DIV_W'(1)) ? '0 : DIV_W'(1);
            end else begin
                state_n = IDLE;
                err_n   = 1'b1;
            end
        end else if (accept) begin
            rem_n    = rem_step;
            cnt_n    = cnt_inc;
            div_ok_n = (rem_step == '0);
            if (order_q == LSB_FIRST) begin
                w_n = w_step;
            end
            if (cnt_inc == len_q) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
        end
    end

    // State and output registers; reset abandons any open frame at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            order_q  <= MSB_FIRST;
            n_q      <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            w_q      <= '0;
            cnt_q    <= '0;
            div_ok_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            order_q  <= order_n;
            n_q      <= n_n;
            len_q    <= len_n;
            rem_q    <= rem_n;
            w_q      <= w_n;
            cnt_q    <= cnt_n;
            div_ok_q <= div_ok_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    assign rem_out    = rem_q;
    assign div_ok     = div_ok_q;
    assign bit_cnt    = cnt_q;
    assign active     = (state_q == ACTIVE);
    assign frame_done = done_q;
    assign cfg_err    = err_q;

endmodule
